// File: rtl/viterbi_decoder.sv
// Hard-decision register-exchange Viterbi decoder for the rate-1/2, K=3 code
// (generators 7 and 5). One decoded bit is emitted per received pair after D pairs.
module viterbi_decoder #(
    parameter int TRACEBACK_DEPTH = 15,
    parameter int METRIC_WIDTH    = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic y,
    input  logic y_valid,
    output logic x_out,
    output logic x_valid
);

    localparam int D     = TRACEBACK_DEPTH;
    localparam int W     = METRIC_WIDTH;
    localparam int CNT_W = $clog2(D + 1);

    localparam logic [W-1:0] PM_MAX  = '1;
    localparam logic [W-1:0] PM_INIT = {1'b1, {(W-1){1'b0}}};

    logic             phase_reg;
    logic             r0_reg;
    logic [W-1:0]     pm_reg   [4];
    // Only D-1 bits are stored: the oldest bit of a D-bit survivor is consumed
    // by the decision in the same cycle it is formed and would never be read.
    logic [D-2:0]     surv_reg [4];
    logic [CNT_W-1:0] pair_cnt_reg;
    logic             x_out_reg;
    logic             x_valid_reg;

    logic [W-1:0]     acs_pm    [4];
    logic [W-1:0]     pm_next   [4];
    logic [D-1:0]     surv_next [4];
    logic [W-1:0]     min_pm;
    logic [1:0]       best_state;
    logic             decision;

    // Next state {b,a} is reached from predecessors {a,0} and {a,1} with input b.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_acs
            localparam int B  = gi / 2;
            localparam int A  = gi % 2;
            localparam int P0 = 2 * A;
            localparam int P1 = 2 * A + 1;

            logic [1:0] bm0, bm1;
            logic [W:0] sum0, sum1;
            logic [W-1:0] cand0, cand1;
            logic take1;

            // Branch from {a,c}: g0 = b^a^c, g1 = b^c
            assign bm0 = {1'b0, r0_reg ^ 1'(B ^ A)}     + {1'b0, y ^ 1'(B)};
            assign bm1 = {1'b0, r0_reg ^ 1'(B ^ A ^ 1)} + {1'b0, y ^ 1'(B ^ 1)};

            assign sum0  = {1'b0, pm_reg[P0]} + {{(W-1){1'b0}}, bm0};
            assign sum1  = {1'b0, pm_reg[P1]} + {{(W-1){1'b0}}, bm1};
            assign cand0 = sum0[W] ? PM_MAX : sum0[W-1:0];
            assign cand1 = sum1[W] ? PM_MAX : sum1[W-1:0];

            // Strict less-than: a tie keeps the {a,0} predecessor.
            assign take1 = (cand1 < cand0);

            assign acs_pm[gi]    = take1 ? cand1 : cand0;
            assign surv_next[gi] = {(take1 ? surv_reg[P1] : surv_reg[P0]), 1'(B)};
            assign pm_next[gi]   = acs_pm[gi] - min_pm;
        end
    endgenerate

    always_comb begin
        min_pm = acs_pm[0];
        for (int i = 1; i < 4; i++) begin
            if (acs_pm[i] < min_pm) begin
                min_pm = acs_pm[i];
            end
        end
    end

    // Scan downwards so the lowest-index zero-metric state wins.
    always_comb begin
        best_state = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (pm_next[i] == '0) begin
                best_state = 2'(i);
            end
        end
    end

    assign decision = surv_next[best_state][D-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg    <= 1'b0;
            r0_reg       <= 1'b0;
            pair_cnt_reg <= '0;
            x_out_reg    <= 1'b0;
            x_valid_reg  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pm_reg[i]   <= (i == 0) ? '0 : PM_INIT;
                surv_reg[i] <= '0;
            end
        end else begin
            x_valid_reg <= 1'b0;
            if (y_valid) begin
                if (!phase_reg) begin
                    r0_reg    <= y;
                    phase_reg <= 1'b1;
                end else begin
                    phase_reg <= 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        pm_reg[i]   <= pm_next[i];
                        surv_reg[i] <= surv_next[i][D-2:0];
                    end
                    if (pair_cnt_reg != CNT_W'(D)) begin
                        pair_cnt_reg <= pair_cnt_reg + 1'b1;
                    end
                    // Counter still holds n-1 while pair n completes.
                    if (pair_cnt_reg >= CNT_W'(D - 1)) begin
                        x_valid_reg <= 1'b1;
                        x_out_reg   <= decision;
                    end
                end
            end
        end
    end

    assign x_out   = x_out_reg;
    assign x_valid = x_valid_reg;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder: a bench-side encoder builds the coded
// stream and a pair-level model predicts every strobe as the delayed info bit.
module tb_viterbi_decoder;

    localparam int D = 15;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic y = 1'b0;
    logic y_valid = 1'b0;
    logic x_out;
    logic x_valid;

    int n_vec = 0;
    int n_miss = 0;

    bit info_q[$];
    bit tx_q[$];
    bit dec_q[$];

    bit m_phase = 1'b0;
    int m_pairs = 0;
    int m_k = 0;
    bit m_xv = 1'b0;
    bit m_x = 1'b0;
    bit m_pair_done = 1'b0;

    viterbi_decoder #(.TRACEBACK_DEPTH(D), .METRIC_WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .y(y),
        .y_valid(y_valid),
        .x_out(x_out),
        .x_valid(x_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: pairs are counted from accepted bits; strobe n >= D carries info bit n-D+1.
    always @(posedge clk) begin
        m_pair_done = 1'b0;
        if (!rst_n) begin
            m_phase = 1'b0;
            m_pairs = 0;
            m_k = 0;
            m_xv = 1'b0;
            m_x = 1'b0;
        end else begin
            m_xv = 1'b0;
            if (y_valid) begin
                if (!m_phase) begin
                    m_phase = 1'b1;
                end else begin
                    m_phase = 1'b0;
                    m_pairs++;
                    m_pair_done = 1'b1;
                    if (m_pairs >= D) begin
                        m_xv = 1'b1;
                        m_x = (m_k < info_q.size()) ? info_q[m_k] : 1'b0;
                        m_k++;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_x_valid", int'(x_valid), 0);
            chk("reset_x_out", int'(x_out), 0);
        end else begin
            chk("x_valid", int'(x_valid), int'(m_xv));
            chk("x_out", int'(x_out), int'(m_x));
            if (x_valid) dec_q.push_back(x_out);
            if (m_pair_done) begin
                int mn;
                mn = int'(dut.pm_reg[0]);
                for (int i = 1; i < 4; i++) if (int'(dut.pm_reg[i]) < mn) mn = int'(dut.pm_reg[i]);
                chk("pm_min_zero", mn, 0);
            end
        end
    end

    task automatic build_tx();
        bit s1, s0, b;
        s1 = 1'b0;
        s0 = 1'b0;
        tx_q.delete();
        foreach (info_q[i]) begin
            b = info_q[i];
            tx_q.push_back(b ^ s1 ^ s0);
            tx_q.push_back(b ^ s0);
            s0 = s1;
            s1 = b;
        end
    endtask

    task automatic set_clean();
        logic [6:0] head;
        head = 7'b1101000;
        info_q.delete();
        for (int i = 0; i < 7; i++) info_q.push_back(head[6-i]);
        for (int i = 0; i < 20; i++) info_q.push_back(1'b0);
        build_tx();
    endtask

    task automatic set_zeros(input int n);
        info_q.delete();
        for (int i = 0; i < n; i++) info_q.push_back(1'b0);
        build_tx();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        y_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        dec_q.delete();
    endtask

    task automatic send_range(input int from, input int to, input int gap);
        for (int i = from; i < to; i++) begin
            y = tx_q[i];
            y_valid = 1'b1;
            @(posedge clk);
            #2;
            y_valid = 1'b0;
            y = 1'b0;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #2;
            end
        end
    endtask

    task automatic finish_test(input string nm, input int exp_n, input logic [6:0] head);
        repeat (4) @(posedge clk);
        #2;
        chk({nm, "_strobes"}, dec_q.size(), exp_n);
        foreach (dec_q[i]) begin
            chk({nm, "_bit"}, int'(dec_q[i]), (i < 7) ? int'(head[6-i]) : 0);
        end
    endtask

    initial begin
        logic [13:0] pat;
        int nz;

        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Pin the bench encoder to the hand-encoded pairs 11 01 01 00 10 11 00.
        set_clean();
        pat = 14'b11010100101100;
        for (int i = 0; i < 14; i++) chk("enc_pin", int'(tx_q[i]), int'(pat[13-i]));

        // Error-free, continuous
        do_reset();
        set_clean();
        send_range(0, tx_q.size(), 0);
        finish_test("clean", 13, 7'b1101000);

        // Single channel error on g1 of pair 3
        do_reset();
        set_clean();
        tx_q[5] = ~tx_q[5];
        send_range(0, 6, 0);
        nz = 0;
        for (int i = 0; i < 4; i++) if (dut.pm_reg[i] != '0) nz = 1;
        chk("err_pm_spread", nz, 1);
        send_range(6, tx_q.size(), 0);
        finish_test("single_err", 13, 7'b1101000);

        // Gaps of 3 cycles between every bit
        do_reset();
        set_clean();
        send_range(0, tx_q.size(), 3);
        finish_test("gapped", 13, 7'b1101000);

        // Reset after 9 bits, then the full stream again
        do_reset();
        set_clean();
        send_range(0, 9, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("midreset_x_valid", int'(x_valid), 0);
        rst_n = 1'b1;
        dec_q.delete();
        send_range(0, tx_q.size(), 0);
        finish_test("midreset", 13, 7'b1101000);

        // Tie rule: first pair 10 from reset gives normalized metrics 0,31,0,31
        do_reset();
        set_zeros(20);
        tx_q[0] = 1'b1;
        send_range(0, 2, 0);
        chk("tie_pm0", int'(dut.pm_reg[0]), 0);
        chk("tie_pm1", int'(dut.pm_reg[1]), 31);
        chk("tie_pm2", int'(dut.pm_reg[2]), 0);
        chk("tie_pm3", int'(dut.pm_reg[3]), 31);
        send_range(2, tx_q.size(), 0);
        finish_test("tie", 6, 7'b0000000);

        // Long run with a two-bit burst every 50 pairs
        do_reset();
        set_zeros(1000);
        for (int p = 0; p < 1000; p++) begin
            if (p % 50 == 25) begin
                tx_q[2*p] = 1'b1;
                tx_q[2*p+1] = 1'b1;
            end
        end
        send_range(0, tx_q.size(), 0);
        finish_test("long", 986, 7'b0000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/viterbi_decoder.md
# viterbi_decoder

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code produced by `conv_encoder`. It sits directly downstream of the encoder, or of the channel model fed by it, and consumes its serial coded bit stream one bit per qualified clock. Survivor paths are kept by register exchange. The block emits one decoded information bit per received bit pair, after a fixed decision delay of TRACEBACK_DEPTH pairs.

## Interface
- `TRACEBACK_DEPTH`, 15: survivor register length D in pairs, and the decision delay. Legal range is 4..32.
- `METRIC_WIDTH`, 6: path-metric width W in bits. Must be at least 4.

Ports:
- `clk`, input, 1: single clock. All state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `y`, input, 1: received coded bit, serial order g0 then g1 for each information bit.
- `y_valid`, input, 1: qualifies `y`. A bit is accepted only on edges where `y_valid=1`.
- `x_out`, output, 1: decoded information bit.
- `x_valid`, output, 1: one-cycle strobe qualifying `x_out`.

## Operation
- Code convention:
  - State s = {s1,s0} = {x[n-1], x[n-2]}.
  - Input b moves state s to {b, s1}.
  - Outputs are g0 = b^s1^s0 (generator 7) and g1 = b^s0 (generator 5).
- Pair assembly:
  - A 1-bit `phase` register toggles on each accepted bit.
  - phase=0 latches `y` as r0. phase=1 completes the pair (r0, y) and performs one trellis step on that edge.
  - After reset, the first accepted bit is always g0.
- Branch metric: Hamming distance (0..2) between (r0, r1) and the (g0, g1) of the branch.
- Add-compare-select (ACS):
  - Each next state {b,a} has predecessors {a,0} and {a,1}.
  - Candidate = pm[pred] + bm, saturating at 2^W−1. The smaller candidate wins.
  - On a tie, the predecessor {a,0} wins.
- Normalization: after ACS, the minimum of the four new metrics is subtracted from all four in the same cycle. After every step at least one metric is 0.
- Register exchange: survivor[s'] = {survivor[winning pred][D−2:0], b}, so bit 0 is the newest decision.
- Decision:
  - Best state is the lowest-index state whose normalized metric is 0.
  - x_out = survivor[best][D−1], the oldest bit.
- Pair counter: saturates at D. Output is enabled once D pairs have been processed.
- Reset values:
  - pm[0]=0; pm[1..3]=2^(W−1).
  - All survivors 0, phase=0, r0=0, pair count 0.
  - x_out=0, x_valid=0.
- Assertion of `rst_n` mid-stream discards all partial pairs and metrics immediately. The next accepted bit after release is treated as g0.
- Flushing: the block has no internal flush. Upstream appends at least D tail zero information bits (zero pairs when encoder state returns to 0) to push out the final bits.

## Timing
- `y_valid` may be held high continuously (one bit per clk) or carry gaps of any length. Gaps do not alter results or phase.
- The trellis step, normalization, survivor update and output register all update on the edge that accepts the second bit of a pair. There is no internal pipeline.
- `x_valid`:
  - Asserted for exactly one cycle after the edge completing pair n, for every n ≥ D.
  - Deasserted in all other cycles, including the cycle after a g0-only edge.
- Latency: information bit k (1-based) appears after the edge completing pair k+D−1. With continuous input and D=15, that is 2(k+14) accepted bits.
- `x_out` holds its value between strobes.
- No backpressure: the consumer must sample on every `x_valid`.

## Test plan
- Error-free stream, D=15, continuous valid:
  - Send pairs 11 01 01 00 10 11 00 (info bits 1101000), then 20 pairs of 00.
  - First `x_valid` appears after pair 15.
  - The first seven strobes give 1,1,0,1,0,0,0; all later strobes give 0.
- Single channel error: same stream with the g1 of pair 3 flipped (01→00).
  - Decoded output is identical to the error-free case.
  - After pair 3, the metric of the best state is 0 and at least one other state's metric is nonzero.
- Gapped input: same stream with `y_valid` low for 3 cycles between every bit, including between g0 and g1.
  - Decoded sequence and strobe count are identical to the continuous case.
  - No `x_valid` is asserted during gaps.
- Reset mid-stream:
  - Assert `rst_n=0` after 9 bits (phase=1), then restart with the full error-free stream.
  - During reset all outputs are 0. The output matches the error-free test exactly, with no stale bits.
- Long run and normalization: 1000 all-zero pairs with a burst of 2 errors every 50 pairs.
  - All 986 strobes output 0.
  - Metrics never exceed 2^W−1, and min(pm)=0 after every step.
- Tie rule: from reset, send pair 10.
  - Check that pm = {1,1,2^(W−1)+…saturated/normalized} per the ACS rules.
  - Check that survivors of next states {0,0} and {1,0} select predecessor {0,0}.
